// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment codes, BCD width and helpers
// Purpose: segment code constants, BCD nibble width, load saturation and the
//          standard seven-segment decoder (segments a..g = bit 0..6, active high).
// Ports:   none (package)
package seg7_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Clamp an out-of-range load nibble to 9 so digits never hold a non-BCD code.
  function automatic logic [BCD_W-1:0] bcd_sat(input logic [BCD_W-1:0] nibble);
    return (nibble > 4'd9) ? 4'd9 : nibble;
  endfunction

  function automatic logic [6:0] seg7_decode(input logic [BCD_W-1:0] nibble);
    logic [6:0] code;
    case (nibble)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_scan_bcd_counter_bcd_digit.sv
// rtl/seg7_scan_bcd_counter_bcd_digit.sv - one decade (0..9) up/down counter stage
// Purpose: single BCD digit with carry/borrow chaining and parallel load.
// Ports:   clk, reset (async, active high), step (count enable for the chain),
//          up_dn (1 up / 0 down), load, load_d[3:0] (already saturated),
//          cin (lower digits all at their rollover value), q[3:0], cout.
module bcd_digit
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             up_dn,
  input  logic             load,
  input  logic [BCD_W-1:0] load_d,
  input  logic             cin,
  output logic [BCD_W-1:0] q,
  output logic             cout
);

  // cout is combinational on the pre-step value so the whole chain resolves
  // within the step cycle.
  assign cout = up_dn ? ((q == 4'd9) && cin) : ((q == 4'd0) && cin);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_d;
    end else if (step && cin) begin
      if (up_dn) q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
      else       q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
    end
  end

endmodule

// File: rtl/seg7_scan_bcd_counter.sv
// rtl/seg7_scan_bcd_counter.sv - prescaled N-digit BCD counter with 7-seg scan driver
// Purpose: decimal up/down counter stepped by a programmable prescaler, with
//          parallel load, wrap flag, leading-zero blanking and a multiplexed
//          seven-segment output stage.
// Ports:   clk, reset (async, active high), tick_cmp (prescaler terminal, 0 = MAX_COUNT),
//          en, up_dn, load, load_val (BCD, digit 0 in [3:0]), bcd_out, tick, wrap,
//          seg[6:0] (a..g), dp, digit_sel (one-hot).
module seg7_scan_bcd_counter
  import seg7_pkg::*;
#(
  parameter int               N_DIGITS  = 4,
  parameter int               CMP_W     = 32,
  parameter logic [CMP_W-1:0] MAX_COUNT = '1,
  parameter int               SCAN_DIV  = 1024,
  parameter int               LZB       = 1,
  parameter int               DP_POS    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CMP_W-1:0]          tick_cmp,
  input  logic                      en,
  input  logic                      up_dn,
  input  logic                      load,
  input  logic [BCD_W*N_DIGITS-1:0] load_val,
  output logic [BCD_W*N_DIGITS-1:0] bcd_out,
  output logic                      tick,
  output logic                      wrap,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [N_DIGITS-1:0]       digit_sel
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SC_W  = $clog2(SCAN_DIV);

  // ---------------- prescaler ----------------
  logic [CMP_W-1:0] pcnt;
  logic [CMP_W-1:0] cmp;
  logic             period_end;
  logic             step;
  logic [N_DIGITS:0] carry;

  assign cmp        = (tick_cmp == '0) ? MAX_COUNT : tick_cmp;
  // >= rather than == so a lowered compare value ends the period right away.
  assign period_end = en && (pcnt >= cmp);
  assign step       = period_end && !load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= step;
      wrap <= step && carry[N_DIGITS];
      if (load || period_end) pcnt <= '0;
      else if (en)            pcnt <= pcnt + CMP_W'(1);
    end
  end

  // ---------------- digit chain ----------------
  logic [BCD_W-1:0] q [N_DIGITS];

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .step   (step),
      .up_dn  (up_dn),
      .load   (load),
      .load_d (bcd_sat(load_val[BCD_W*g +: BCD_W])),
      .cin    (carry[g]),
      .q      (q[g]),
      .cout   (carry[g+1])
    );
    assign bcd_out[BCD_W*g +: BCD_W] = q[g];
  end

  // ---------------- scan rotation ----------------
  logic [SC_W-1:0]  scan_cnt;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SC_W'(1);
    end
  end

  // ---------------- digit select, blanking, decode ----------------
  logic [N_DIGITS:0]   zero_from;  // zero_from[k]: digits k..N-1 are all zero
  logic [BCD_W-1:0]    nib;
  logic                blank_sel;
  logic                dp_c;
  logic [6:0]          seg_c;
  logic [N_DIGITS-1:0] sel_c;

  always_comb begin
    zero_from           = '0;
    zero_from[N_DIGITS] = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (q[k] == '0);
    end

    nib       = '0;
    blank_sel = 1'b0;
    dp_c      = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nib       = q[k];
        blank_sel = (LZB != 0) && (k != 0) && zero_from[k];
        dp_c      = (k == DP_POS);
      end
    end

    seg_c = blank_sel ? SEG_BLANK : seg7_decode(nib);
    sel_c = N_DIGITS'(1) << idx;
  end

  // seg, dp and digit_sel share one register stage so they always change together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg       <= SEG_0;
      dp        <= (DP_POS == 0);
      digit_sel <= N_DIGITS'(1);
    end else begin
      seg       <= seg_c;
      dp        <= dp_c;
      digit_sel <= sel_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan_bcd_counter.sv
// tb/tb_seg7_scan_bcd_counter.sv - scoreboard bench for seg7_scan_bcd_counter
module tb_seg7_scan_bcd_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] tick_cmp;
  logic        en;
  logic        up_dn;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] bcd_out;
  logic        tick;
  logic        wrap;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_sel;

  always #5 clk = ~clk;

  seg7_scan_bcd_counter #(
    .N_DIGITS  (4),
    .CMP_W     (32),
    .MAX_COUNT (32'hFFFF_FFFF),
    .SCAN_DIV  (4),
    .LZB       (1),
    .DP_POS    (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_cmp  (tick_cmp),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_val  (load_val),
    .bcd_out   (bcd_out),
    .tick      (tick),
    .wrap      (wrap),
    .seg       (seg),
    .dp        (dp),
    .digit_sel (digit_sel)
  );

  typedef struct {
    int          cyc;
    logic [15:0] bcd;
    logic        wrap;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  bit          mon_on = 1'b0;
  int          m_val;
  longint      m_p;
  logic [6:0]  segt [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int p10(input int k);
    int r = 1;
    repeat (k) r *= 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((v / p10(k)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int k);
    if (k > 0 && m_val < p10(k)) return 7'h00;
    return segt[(m_val / p10(k)) % 10];
  endfunction

  // Reference: value kept as a plain integer 0..9999, prescaler as a cycle count.
  task automatic model_step(input bit e, input bit u, input bit l,
                            input logic [15:0] lv, input logic [31:0] c);
    longint cmpv;
    int     n;
    bit     w;
    cmpv = (c == 0) ? 64'h0000_0000_FFFF_FFFF : longint'(c);
    if (l) begin
      m_val = 0;
      for (int k = 0; k < 4; k++) begin
        n = int'(lv[4*k +: 4]);
        if (n > 9) n = 9;
        m_val += n * p10(k);
      end
      m_p = 0;
    end else if (e) begin
      if (m_p >= cmpv) begin
        m_p = 0;
        if (u) begin
          w     = (m_val == 9999);
          m_val = (m_val + 1) % 10000;
        end else begin
          w     = (m_val == 0);
          m_val = (m_val + 9999) % 10000;
        end
        sb.push_back('{cyc + 1, to_bcd(m_val), w});
      end else begin
        m_p++;
      end
    end
  endtask

  task automatic drive(input bit e, input bit u, input bit l,
                       input logic [15:0] lv, input logic [31:0] c);
    en = e; up_dn = u; load = l; load_val = lv; tick_cmp = c;
    model_step(e, u, l, lv, c);
    @(negedge clk);
  endtask

  // Monitor: every tick must match the oldest expected step, at the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on && !reset) begin
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk("tick_present", {31'b0, tick}, 32'd1);
        chk("step_value", {16'b0, bcd_out}, {16'b0, e.bcd});
        chk("wrap_flag", {31'b0, wrap}, {31'b0, e.wrap});
      end else begin
        chk("no_tick", {30'b0, tick, wrap}, 32'd0);
      end
    end
  end

  initial begin
    logic [3:0] prev_sel;
    int         last_chg;
    int         nchg;
    int         k;

    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0; tick_cmp = 32'd3;
    m_val = 0; m_p = 0;
    repeat (3) @(negedge clk);

    chk("rst_bcd", {16'b0, bcd_out}, 32'h0);
    chk("rst_tick", {30'b0, tick, wrap}, 32'h0);
    chk("rst_sel", {28'b0, digit_sel}, 32'h1);
    chk("rst_seg", {25'b0, seg}, 32'h3F);
    chk("rst_dp", {31'b0, dp}, 32'h1);

    reset  = 1'b0;
    mon_on = 1'b1;

    // Count up with period 4
    repeat (36) drive(1, 1, 0, 16'h0, 32'd3);
    chk("count_9", {16'b0, bcd_out}, 32'h0009);
    repeat (4) drive(1, 1, 0, 16'h0, 32'd3);
    chk("count_10", {16'b0, bcd_out}, 32'h0010);

    // Wrap up and down
    drive(1, 1, 1, 16'h9999, 32'd3);
    chk("load_9999", {16'b0, bcd_out}, 32'h9999);
    repeat (4) drive(1, 1, 0, 16'h0, 32'd3);
    chk("wrap_up_val", {16'b0, bcd_out}, 32'h0000);
    repeat (4) drive(1, 0, 0, 16'h0, 32'd3);
    chk("wrap_dn_val", {16'b0, bcd_out}, 32'h9999);

    // Load colliding with a step, saturating nibbles
    repeat (3) drive(1, 1, 0, 16'h0, 32'd3);
    drive(1, 1, 1, 16'h12AF, 32'd3);
    chk("load_sat", {16'b0, bcd_out}, 32'h1299);
    chk("load_no_tick", {30'b0, tick, wrap}, 32'h0);
    repeat (4) drive(1, 1, 0, 16'h0, 32'd3);
    chk("after_load_step", {16'b0, bcd_out}, 32'h1300);

    // Scan rotation and blanking with the counter frozen
    drive(0, 1, 1, 16'h0042, 32'd3);
    repeat (2) drive(0, 1, 0, 16'h0, 32'd3);
    prev_sel = digit_sel;
    last_chg = -1;
    nchg     = 0;
    repeat (24) begin
      drive(0, 1, 0, 16'h0, 32'd3);
      chk("sel_onehot", $countones(digit_sel), 32'd1);
      k = 0;
      for (int i = 0; i < 4; i++) if (digit_sel[i]) k = i;
      chk("scan_seg", {25'b0, seg}, {25'b0, exp_seg(k)});
      chk("scan_dp", {31'b0, dp}, {31'b0, (k == 0)});
      if (digit_sel !== prev_sel) begin
        if (last_chg >= 0) chk("scan_period", cyc - last_chg, 32'd4);
        chk("scan_order", {28'b0, digit_sel}, {28'b0, prev_sel[2:0], prev_sel[3]});
        last_chg = cyc;
        nchg++;
        prev_sel = digit_sel;
      end
    end
    chk("frozen_val", {16'b0, bcd_out}, 32'h0042);
    chk("scan_runs", {31'b0, (nchg >= 4)}, 32'd1);

    // Lowering tick_cmp mid-period
    drive(1, 1, 1, 16'h0000, 32'd100);
    repeat (50) drive(1, 1, 0, 16'h0, 32'd100);
    drive(1, 1, 0, 16'h0, 32'd2);
    chk("cmp_drop_tick", {31'b0, tick}, 32'd1);
    repeat (9) drive(1, 1, 0, 16'h0, 32'd2);
    repeat (10) drive(0, 1, 0, 16'h0, 32'd2);
    chk("en0_hold", {16'b0, bcd_out}, {16'b0, to_bcd(m_val)});
    chk("cmp_drop_val", {16'b0, bcd_out}, 32'h0004);

    // Randomised traffic
    for (int it = 0; it < 400; it++) begin
      drive($urandom_range(0, 9) != 0,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 29) == 0,
            16'($urandom),
            ($urandom_range(0, 12) == 0) ? 32'd0 : 32'($urandom_range(1, 4)));
    end
    drive(1, 1, 1, 16'h0357, 32'd1);
    repeat (5) drive(1, 1, 0, 16'h0, 32'd1);

    // Asynchronous reset between edges
    #3 reset = 1'b1;
    #1;
    chk("arst_bcd", {16'b0, bcd_out}, 32'h0);
    chk("arst_sel", {28'b0, digit_sel}, 32'h1);
    chk("arst_seg", {25'b0, seg}, 32'h3F);
    chk("arst_tick", {31'b0, tick}, 32'h0);
    while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
    m_val = 0;
    m_p   = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) drive(1, 1, 0, 16'h0, 32'd2);
    repeat (3) drive(0, 1, 0, 16'h0, 32'd2);
    chk("final_val", {16'b0, bcd_out}, {16'b0, to_bcd(m_val)});
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
